// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and op-decode helpers for the iterative
// RV32M/RV64M multiply/divide unit.
//   muldiv_op_e    - operation code, equal to funct3
//   muldiv_state_e - control FSM states
//   is_div / is_rem / is_signed_a / is_signed_b - op classification
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(input muldiv_op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic is_signed_a(input muldiv_op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(input muldiv_op_e op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_neg.sv
// muldiv_neg: parametrised-width conditional two's-complement negate.
//   neg - negate when set
//   in  - W-bit operand
//   out - neg ? -in : in
module muldiv_neg #(
   parameter int unsigned W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] in,
   output logic [W-1:0] out
);

   assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit (all eight ops).
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, followed by a sign-fix cycle. Divide-by-zero and signed overflow
// complete without iterating.
//   clk, rst_n      - clock, asynchronous active-low reset
//   start_i         - request; accepted when start_i && ready_o && !kill_i
//   op_i            - funct3 op code (muldiv_op_e)
//   a_i, b_i        - rs1 / rs2 operands, captured at acceptance
//   kill_i          - flush; aborts any operation in flight
//   ready_o         - unit can accept a request this cycle
//   valid_o         - one-cycle result strobe
//   result_o        - result, held until the next operation completes
// Optional build macro: MULDIV_EARLY_OUT_EN - multiply leaves CALC as soon as
// the remaining multiplier bits are all zero.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            kill_i,
   output logic            ready_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CW = $clog2(XLEN);

   muldiv_state_e   state, state_n;
   muldiv_op_e      op_in, op_q;
   logic [CW-1:0]   cnt;
   logic            neg_q;
   // mul: product accumulator; div: {remainder, dividend/quotient}
   logic [2*XLEN-1:0] acc;
   // mul: left-shifting multiplicand; div: divisor in the low half
   logic [2*XLEN-1:0] mcand;
   // mul: right-shifting multiplier (operand a); unused for div
   logic [XLEN-1:0]   mplier;
   logic [XLEN-1:0]   result_q;

   logic            accept;
   logic            a_sign, b_sign;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_by_zero, overflow, special;
   logic [XLEN-1:0] special_res;
   logic            calc_last;

   logic [2*XLEN-1:0] prod_add;
   logic [XLEN:0]     rem_sh, trial;
   logic [2*XLEN-1:0] div_acc;
   logic [2*XLEN-1:0] fix_in, fix_out;
   logic [XLEN-1:0]   fix_res;

   assign op_in   = muldiv_op_e'(op_i);
   assign ready_o = (state == ST_IDLE) || (state == ST_DONE);
   assign valid_o = (state == ST_DONE);
   assign result_o = result_q;
   assign accept  = start_i && ready_o && !kill_i;

   // ---------------- acceptance: magnitudes and special cases ----------------
   assign a_sign = a_i[XLEN-1] & is_signed_a(op_in);
   assign b_sign = b_i[XLEN-1] & is_signed_b(op_in);

   muldiv_neg #(.W(XLEN)) u_neg_a (.neg(a_sign), .in(a_i), .out(a_mag));
   muldiv_neg #(.W(XLEN)) u_neg_b (.neg(b_sign), .in(b_i), .out(b_mag));

   assign div_by_zero = is_div(op_in) && (b_i == '0);
   assign overflow    = (op_in inside {OP_DIV, OP_REM}) &&
                        (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
   assign special     = div_by_zero || overflow;

   always_comb begin
      special_res = '0;
      if (div_by_zero)
         special_res = is_rem(op_in) ? a_i : '1;
      else
         special_res = is_rem(op_in) ? '0 : a_i;
   end

   // ---------------- CALC datapath ----------------
   assign prod_add = mplier[0] ? (acc + mcand) : acc;

   // Shift the next dividend bit into the remainder and try the subtract.
   // A failed subtract always has rem_sh[XLEN] clear, so dropping it is safe.
   assign rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign trial   = rem_sh - {1'b0, mcand[XLEN-1:0]};
   assign div_acc = trial[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {trial[XLEN-1:0],  acc[XLEN-2:0], 1'b1};

`ifdef MULDIV_EARLY_OUT_EN
   assign calc_last = (cnt == CW'(XLEN-1)) ||
                      (!is_div(op_q) && (mplier[XLEN-1:1] == '0));
`else
   assign calc_last = (cnt == CW'(XLEN-1));
`endif

   // ---------------- FIX datapath ----------------
   // Divide results are zero-extended into the shared 2*XLEN negator and
   // taken from its low half.
   always_comb begin
      fix_in = acc;
      if (is_div(op_q))
         fix_in = is_rem(op_q) ? {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]}
                               : {{XLEN{1'b0}}, acc[XLEN-1:0]};
   end

   muldiv_neg #(.W(2*XLEN)) u_neg_fix (.neg(neg_q), .in(fix_in), .out(fix_out));

   assign fix_res = ((op_q == OP_MUL) || is_div(op_q)) ? fix_out[XLEN-1:0]
                                                       : fix_out[2*XLEN-1:XLEN];

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (accept) state_n = special ? ST_DONE : ST_CALC;
         ST_CALC: if (calc_last) state_n = ST_FIX;
         ST_FIX:  state_n = ST_DONE;
         ST_DONE: state_n = accept ? (special ? ST_DONE : ST_CALC) : ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      if (kill_i) state_n = ST_IDLE;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_MUL;
         neg_q    <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q  <= op_in;
         neg_q <= (is_div(op_in) && is_rem(op_in)) ? a_sign : (a_sign ^ b_sign);
         cnt   <= '0;
         if (special) begin
            result_q <= special_res;
         end else if (is_div(op_in)) begin
            acc    <= {{XLEN{1'b0}}, a_mag};
            mcand  <= {{XLEN{1'b0}}, b_mag};
            mplier <= '0;
         end else begin
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, b_mag};
            mplier <= a_mag;
         end
      end else if (!kill_i && (state == ST_CALC)) begin
         cnt <= cnt + 1'b1;
         if (is_div(op_q)) begin
            acc <= div_acc;
         end else begin
            acc    <= prod_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end
      end else if (!kill_i && (state == ST_FIX)) begin
         result_q <= fix_res;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (XLEN = 32).
// Random and directed operations are checked against an arithmetic reference
// model (64-bit products, native signed/unsigned division) plus the expected
// latency for each operation.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        kill_i;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] result_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_exp;

   muldiv_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .kill_i   (kill_i),
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .result_o (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0] p;
      logic        ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      logic [31:0] mag;
      int bits;
      if (op >= 3'd4) begin
         if (b == 0) return 1;
         if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
         return 34;
      end
`ifdef MULDIV_EARLY_OUT_EN
      mag  = ((op == 3'd1 || op == 3'd2) && a[31]) ? (0 - a) : a;
      bits = 0;
      for (int i = 0; i < 32; i++) if ((mag >> i) != 0) bits = i + 1;
      if (bits < 1) bits = 1;
      return bits + 2;
`else
      mag  = a;
      bits = 32;
      return (mag == mag) ? bits + 2 : 0;
`endif
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Issues one request in the current cycle (cycle 0) and waits for valid_o.
   // Returns in the DONE cycle so a following call is a back-to-back issue.
   // poke: cycle in which a second start_i is held while busy (0 = none).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke, output logic [31:0] res, output int lat,
                         output int rdy_bad);
      lat = -1; res = '0; rdy_bad = 0;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      step();
      start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
      for (int k = 1; k <= 60; k++) begin
         if (valid_o) begin lat = k; res = result_o; break; end
         if (ready_o) rdy_bad++;
         start_i = (k == poke);
         if (k == poke) begin op_i = 3'd5; a_i = 32'd9; b_i = 32'd3; end
         step();
      end
      start_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
      repeat (3) step();
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
      checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
      rst_n = 1'b1;
      step();
      last_exp = '0;
   endtask

   task automatic test_signed_div();
      logic [31:0] r; int lat, rb;
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, r, lat, rb);
      checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg got %h want fffffffd", r); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL div_lat got %0d want 34", lat); end
      checks++; if (rb !== 0) begin errors++; $display("FAIL div_ready_busy got %0d ready-high cycles want 0", rb); end
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL div_valid_width got %b want 0", valid_o); end
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, r, lat, rb);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg got %h want ffffffff", r); end
      last_exp = 32'hFFFF_FFFF;
   endtask

   task automatic test_div_zero();
      logic [2:0]  ops [3] = '{3'd5, 3'd7, 3'd4};
      logic [31:0] as  [3] = '{32'd100, 32'd100, 32'd0};
      logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF};
      logic [31:0] r; int lat, rb;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], as[i], 32'd0, 0, r, lat, rb);
         checks++; if (r !== exp[i]) begin errors++; $display("FAIL divzero_%0d got %h want %h", i, r, exp[i]); end
         checks++; if (lat !== 1) begin errors++; $display("FAIL divzero_lat_%0d got %0d want 1", i, lat); end
         last_exp = exp[i];
      end
   endtask

   task automatic test_overflow();
      logic [31:0] r; int lat, rb;
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, lat, rb);
      checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div got %h want 80000000", r); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_lat got %0d want 1", lat); end
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, lat, rb);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL ovf_rem got %h want 0", r); end
      last_exp = 32'd0;
   endtask

   task automatic test_mul_variants();
      logic [2:0]  ops [4] = '{3'd1, 3'd3, 3'd2, 3'd0};
      logic [31:0] as  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bs  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp [4] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
      logic [31:0] r; int lat, rb;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], 0, r, lat, rb);
         checks++; if (r !== exp[i]) begin errors++; $display("FAIL mul_%0d got %h want %h", i, r, exp[i]); end
         checks++; if (lat !== exp_lat(ops[i], as[i], bs[i])) begin
            errors++; $display("FAIL mul_lat_%0d got %0d want %0d", i, lat, exp_lat(ops[i], as[i], bs[i])); end
         last_exp = exp[i];
      end
      run_op(3'd0, 32'd5, 32'd3, 0, r, lat, rb);
      checks++; if (r !== 32'd15) begin errors++; $display("FAIL mul_5x3 got %0d want 15", r); end
`ifdef MULDIV_EARLY_OUT_EN
      checks++; if (lat !== 5) begin errors++; $display("FAIL mul_5x3_lat got %0d want 5", lat); end
`else
      checks++; if (lat !== 34) begin errors++; $display("FAIL mul_5x3_lat got %0d want 34", lat); end
`endif
      last_exp = 32'd15;
   endtask

   task automatic test_busy();
      logic [31:0] r; int lat, rb;
      run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 5, r, lat, rb);
      checks++; if (r !== model(3'd4, 32'd1000, 32'hFFFF_FFF9)) begin
         errors++; $display("FAIL busy_result got %h want %h", r, model(3'd4, 32'd1000, 32'hFFFF_FFF9)); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL busy_lat got %0d want 34", lat); end
      last_exp = model(3'd4, 32'd1000, 32'hFFFF_FFF9);
      step();
   endtask

   task automatic test_kill();
      int seen;
      start_i = 1'b1; op_i = 3'd4; a_i = 32'd12345; b_i = 32'd7;
      step();
      start_i = 1'b0;
      repeat (9) step();
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL kill_idle_ready got %b want 1", ready_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL kill_idle_valid got %b want 0", valid_o); end
      seen = 0;
      for (int k = 0; k < 40; k++) begin if (valid_o) seen++; step(); end
      checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_valid got %0d strobes want 0", seen); end
      checks++; if (result_o !== last_exp) begin errors++; $display("FAIL kill_result got %h want %h", result_o, last_exp); end
      // kill beats a simultaneous start in IDLE
      start_i = 1'b1; kill_i = 1'b1; op_i = 3'd5; a_i = 32'd50; b_i = 32'd5;
      step();
      start_i = 1'b0; kill_i = 1'b0;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL kill_prio_ready got %b want 1", ready_o); end
      seen = 0;
      for (int k = 0; k < 40; k++) begin if (valid_o) seen++; step(); end
      checks++; if (seen !== 0) begin errors++; $display("FAIL kill_prio_no_valid got %0d strobes want 0", seen); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; int lat, rb;
      run_op(3'd5, 32'd100, 32'd7, 0, r, lat, rb);
      checks++; if (r !== 32'd14) begin errors++; $display("FAIL b2b_first got %0d want 14", r); end
      run_op(3'd5, 32'd7, 32'd2, 0, r, lat, rb);
      checks++; if (r !== 32'd3) begin errors++; $display("FAIL b2b_divu got %0d want 3", r); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_lat got %0d want 34", lat); end
      run_op(3'd7, 32'd7, 32'd2, 0, r, lat, rb);
      checks++; if (r !== 32'd1) begin errors++; $display("FAIL b2b_remu got %0d want 1", r); end
      last_exp = 32'd1;
   endtask

   task automatic test_random();
      logic [2:0] op; logic [31:0] a, b, r, e; int lat, rb, sel;
      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (sel == 2) b = b >> $urandom_range(0, 31);
         e = model(op, a, b);
         run_op(op, a, b, 0, r, lat, rb);
         checks++; if (r !== e) begin
            errors++; $display("FAIL rand_%0d op %0d a %h b %h got %h want %h", n, op, a, b, r, e); end
         checks++; if (lat !== exp_lat(op, a, b)) begin
            errors++; $display("FAIL rand_lat_%0d op %0d got %0d want %0d", n, op, lat, exp_lat(op, a, b)); end
         last_exp = e;
         if (sel == 3) step();
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      start_i = 1'b1; op_i = 3'd0; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF1;
      step();
      start_i = 1'b0;
      repeat (19) step();
      rst_n = 1'b0;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", ready_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", valid_o); end
      checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", result_o); end
      #2 rst_n = 1'b1;
      step();
      seen = 0;
      for (int k = 0; k < 40; k++) begin if (valid_o) seen++; step(); end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_valid got %0d strobes want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_signed_div();
      test_div_zero();
      test_overflow();
      test_mul_variants();
      test_busy();
      test_kill();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
